// File: rtl/sram_frame_unpacker_pkg.sv
// Shared types and constants for the SRAM frame unpacker: FSM states,
// header field width, CRC constants and the body word-count helper.
package frame_pkg;

    localparam int          HDR_LEN_MSB = 10;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE,
        HDR_RD,
        HDR_WAIT,
        LEN_CHK,
        WAIT_BODY,
        WORD_RD,
        WORD_WAIT,
        EMIT_HI,
        EMIT_LO,
        DONE
    } state_t;

    // ceil(len/2); the extra bit keeps len=2047 from wrapping
    function automatic logic [HDR_LEN_MSB:0] words_for_len(input logic [HDR_LEN_MSB:0] len);
        logic [HDR_LEN_MSB+1:0] sum;
        sum = {1'b0, len} + 1'b1;
        return sum[HDR_LEN_MSB+1:1];
    endfunction

endpackage

// File: rtl/sram_frame_unpacker_crc16.sv
// Byte-wide CRC-16/CCITT-FALSE step (MSB first, no reflection) with
// synchronous clear to the initial value and an enable per accepted byte.
module crc16_ccitt_byte
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] r_crc;
    logic [15:0] w_next;
    logic [7:0]  w_shift;

    always_comb begin
        w_next  = r_crc;
        w_shift = din;
        for (int unsigned i = 0; i < 8; i++) begin
            w_next  = {w_next[14:0], 1'b0} ^ ((w_next[15] ^ w_shift[7]) ? CRC16_POLY : '0);
            w_shift = {w_shift[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= '0;
        end else if (clr) begin
            r_crc <= CRC16_INIT;
        end else if (en) begin
            r_crc <= w_next;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sram_frame_unpacker.sv
// Pops length-prefixed frames of 16-bit words from the SRAM output FIFO and
// streams the body as bytes. Optional CRC-16 under macro UNPACK_CRC16_EN.
module sram_frame_unpacker
    import frame_pkg::*;
#(
    parameter int unsigned RD_LATENCY      = 2,
    parameter int unsigned MAX_FRAME_BYTES = 64,
    parameter int unsigned CNT_W           = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sram_hint,
    input  logic             sram_empty,
    input  logic [CNT_W-1:0] sram_count,
    input  logic [15:0]      sram_data,
    output logic             sram_read,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             byte_first,
    output logic             byte_last,
    output logic [10:0]      frame_len,
    output logic             busy,
    output logic             len_err,
    output logic [15:0]      crc16,
    output logic             crc_valid
);

    localparam int unsigned LAT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY);

    state_t                 r_state;
    logic [LAT_W-1:0]       r_wait;
    logic [HDR_LEN_MSB:0]   r_len;
    logic [10:0]            r_frame_len;
    logic [HDR_LEN_MSB:0]   r_remain;
    logic [15:0]            r_word;
    logic                   r_first;
    logic                   r_busy;
    logic                   r_len_err;

    logic                   w_pop;
    logic                   w_accept;
    logic                   w_len_bad;
    logic                   w_body_ready;
    logic                   w_rd_done;
    logic [HDR_LEN_MSB:0]   w_words;

    // sram_read is decoded from the current inputs so a pop can never be
    // issued in a cycle where the grant or non-empty condition is absent.
    assign w_pop     = ((r_state == HDR_RD) || (r_state == WORD_RD)) && sram_hint && !sram_empty;
    assign sram_read = w_pop;

    assign byte_valid = (r_state == EMIT_HI) || (r_state == EMIT_LO);
    assign byte_data  = (r_state == EMIT_HI) ? r_word[15:8] :
                        (r_state == EMIT_LO) ? r_word[7:0]  : '0;
    assign byte_first = byte_valid && r_first;
    assign byte_last  = byte_valid && (r_remain == 11'd1);
    assign w_accept   = byte_valid && byte_ready;

    assign w_len_bad    = (r_len == '0) || (32'(r_len) > MAX_FRAME_BYTES);
    assign w_words      = words_for_len(r_len);
    assign w_body_ready = 32'(sram_count) >= 32'(w_words);
    // Pop is issued in the *_RD cycle, so the wait state spans RD_LATENCY-1
    // further cycles before sram_data is valid.
    assign w_rd_done    = (32'(r_wait) >= RD_LATENCY - 1);

    assign frame_len = r_frame_len;
    assign busy      = r_busy;
    assign len_err   = r_len_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            r_len       <= '0;
            r_frame_len <= '0;
            r_remain    <= '0;
            r_word      <= '0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            unique case (r_state)
                IDLE: if (!sram_empty) r_state <= HDR_RD;
                HDR_RD: if (w_pop) begin
                    r_wait  <= '0;
                    r_state <= HDR_WAIT;
                end
                HDR_WAIT: if (w_rd_done) begin
                    r_len   <= sram_data[HDR_LEN_MSB:0];
                    r_state <= LEN_CHK;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
                LEN_CHK: if (w_len_bad) begin
                    r_len_err <= 1'b1;
                    r_state   <= IDLE;
                end else begin
                    r_busy      <= 1'b1;
                    r_frame_len <= r_len;
                    r_remain    <= r_len;
                    r_first     <= 1'b1;
                    r_state     <= WAIT_BODY;
                end
                WAIT_BODY: if (w_body_ready) r_state <= WORD_RD;
                WORD_RD: if (w_pop) begin
                    r_wait  <= '0;
                    r_state <= WORD_WAIT;
                end
                WORD_WAIT: if (w_rd_done) begin
                    r_word  <= sram_data;
                    r_state <= EMIT_HI;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
                EMIT_HI, EMIT_LO: if (w_accept) begin
                    r_remain <= r_remain - 1'b1;
                    r_first  <= 1'b0;
                    if (r_remain == 11'd1) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_state <= (r_state == EMIT_HI) ? EMIT_LO : WORD_RD;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef UNPACK_CRC16_EN
    crc16_ccitt_byte u_crc (
        .clk (clk),
        .rst (rst),
        .clr (r_state == LEN_CHK),
        .en  (w_accept),
        .din (byte_data),
        .crc (crc16)
    );
    assign crc_valid = (r_state == DONE);
`else
    assign crc16     = '0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sram_frame_unpacker.sv
// Directed self-checking bench for sram_frame_unpacker with a small SRAM
// FIFO model returning data two cycles after each pop.
module tb_sram_frame_unpacker;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sram_hint = 1'b1;
    logic             sram_empty;
    logic [CNT_W-1:0] sram_count;
    logic [15:0]      sram_data = '0;
    logic             sram_read;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready = 1'b1;
    logic             byte_first;
    logic             byte_last;
    logic [10:0]      frame_len;
    logic             busy;
    logic             len_err;
    logic [15:0]      crc16;
    logic             crc_valid;

    sram_frame_unpacker #(
        .RD_LATENCY      (2),
        .MAX_FRAME_BYTES (64),
        .CNT_W           (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sram_hint  (sram_hint),
        .sram_empty (sram_empty),
        .sram_count (sram_count),
        .sram_data  (sram_data),
        .sram_read  (sram_read),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_first (byte_first),
        .byte_last  (byte_last),
        .frame_len  (frame_len),
        .busy       (busy),
        .len_err    (len_err),
        .crc16      (crc16),
        .crc_valid  (crc_valid)
    );

    always #5 clk = ~clk;

    // SRAM FIFO model
    logic [15:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [15:0] pend = '0;
    logic        flush = 1'b0;

    assign sram_count = CNT_W'(wr_ptr - rd_ptr);
    assign sram_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (sram_read) begin
            pend   <= mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
        end
        sram_data <= pend;
    end

    // Event monitors
    int cyc = 0, n_reads = 0, last_rd = -1, min_gap = 1000, bad_rd = 0;
    int n_acc = 0, n_vcyc = 0, n_lenerr = 0, n_crcv = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_read) begin
            n_reads <= n_reads + 1;
            if (last_rd >= 0 && (cyc - last_rd) < min_gap) min_gap <= cyc - last_rd;
            last_rd <= cyc;
            if (!sram_hint || sram_empty) bad_rd <= bad_rd + 1;
        end
        if (byte_valid && byte_ready) n_acc <= n_acc + 1;
        if (byte_valid) n_vcyc <= n_vcyc + 1;
        if (len_err) n_lenerr <= n_lenerr + 1;
        if (crc_valid) n_crcv <= n_crcv + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (byte_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(byte_valid), 32'd1);
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] d, input logic f, input logic l);
        chk({tag, "_data"}, 32'(byte_data), 32'(d));
        chk({tag, "_first"}, 32'(byte_first), 32'(f));
        chk({tag, "_last"}, 32'(byte_last), 32'(l));
    endtask

    // Wait for a byte, check it, and let it be accepted (byte_ready=1).
    task automatic take(input string tag, input logic [7:0] d, input logic f, input logic l);
        wait_valid(tag);
        chk_byte(tag, d, f, l);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    int r0, v0, a0, l0, c0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sram_read", 32'(sram_read), 32'd0);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_crc16", 32'(crc16), 32'd0);
        chk("rst_crc_valid", 32'(crc_valid), 32'd0);
        rst = 1'b0;

        // Even length, hint always high
        r0 = n_reads;
        push(16'h0004); push(16'hA1B2); push(16'hC3D4);
        wait_valid("ev_b0");
        chk("ev_frame_len", 32'(frame_len), 32'd4);
        chk("ev_busy", 32'(busy), 32'd1);
        take("ev_b0", 8'hA1, 1'b1, 1'b0);
        take("ev_b1", 8'hB2, 1'b0, 1'b0);
        take("ev_b2", 8'hC3, 1'b0, 1'b0);
        take("ev_b3", 8'hD4, 1'b0, 1'b1);
        wait_idle("ev");
        chk("ev_reads", 32'(n_reads - r0), 32'd3);

        // Odd length with backpressure; 0xFF pad byte must not appear
        a0 = n_acc;
        push(16'h0003); push(16'h1122); push(16'h33FF);
        take("od_b0", 8'h11, 1'b1, 1'b0);
        byte_ready = 1'b0;
        chk_byte("od_b1", 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        chk_byte("od_b1_hold1", 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        chk_byte("od_b1_hold2", 8'h22, 1'b0, 1'b0);
        chk("od_b1_valid_hold", 32'(byte_valid), 32'd1);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        wait_valid("od_b2");
        chk_byte("od_b2", 8'h33, 1'b0, 1'b1);
        @(negedge clk);
        chk_byte("od_b2_hold", 8'h33, 1'b0, 1'b1);
        byte_ready = 1'b1;
        @(negedge clk);
        chk("od_after_last_valid", 32'(byte_valid), 32'd0);
        wait_idle("od");
        chk("od_accepted", 32'(n_acc - a0), 32'd3);

        // Illegal lengths: L=0 then a good L=2 frame, then L=65
        l0 = n_lenerr;
        push(16'h0000); push(16'h0002); push(16'h5566);
        take("il_b0", 8'h55, 1'b1, 1'b0);
        take("il_b1", 8'h66, 1'b0, 1'b1);
        wait_idle("il");
        chk("il_lenerr_zero", 32'(n_lenerr - l0), 32'd1);
        v0 = n_vcyc;
        push(16'h0041);
        repeat (12) @(negedge clk);
        chk("il_lenerr_65", 32'(n_lenerr - l0), 32'd2);
        chk("il_65_no_bytes", 32'(n_vcyc - v0), 32'd0);
        chk("il_65_hdr_only", 32'(sram_empty), 32'd1);

        // Body not yet resident: L=6 with only one body word present
        push(16'h0006); push(16'h0102);
        repeat (10) @(negedge clk);
        chk("nr_busy", 32'(busy), 32'd1);
        r0 = n_reads;
        v0 = n_vcyc;
        repeat (50) @(negedge clk);
        chk("nr_no_reads", 32'(n_reads - r0), 32'd0);
        chk("nr_no_valid", 32'(n_vcyc - v0), 32'd0);
        push(16'h0304); push(16'h0506);
        take("nr_b0", 8'h01, 1'b1, 1'b0);
        take("nr_b1", 8'h02, 1'b0, 1'b0);
        take("nr_b2", 8'h03, 1'b0, 1'b0);
        take("nr_b3", 8'h04, 1'b0, 1'b0);
        take("nr_b4", 8'h05, 1'b0, 1'b0);
        take("nr_b5", 8'h06, 1'b0, 1'b1);
        wait_idle("nr");

        // Reset mid-frame after the first byte of an L=4 frame
        push(16'h0004); push(16'hAABB); push(16'hCCDD);
        take("rm_b0", 8'hAA, 1'b1, 1'b0);
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("rm_byte_valid", 32'(byte_valid), 32'd0);
        chk("rm_byte_data", 32'(byte_data), 32'd0);
        chk("rm_byte_first", 32'(byte_first), 32'd0);
        chk("rm_byte_last", 32'(byte_last), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_frame_len", 32'(frame_len), 32'd0);
        chk("rm_sram_read", 32'(sram_read), 32'd0);
        chk("rm_crc16", 32'(crc16), 32'd0);
        rst = 1'b0;
        flush = 1'b0;
        r0 = n_reads;
        repeat (10) @(negedge clk);
        chk("rm_no_reads", 32'(n_reads - r0), 32'd0);

        // CRC frame "123456789", hint held low first to stall the pop
        sram_hint = 1'b0;
        r0 = n_reads;
        c0 = n_crcv;
        push(16'h0009); push(16'h3132); push(16'h3334);
        push(16'h3536); push(16'h3738); push(16'h3900);
        repeat (15) @(negedge clk);
        chk("hint_stall_reads", 32'(n_reads - r0), 32'd0);
        sram_hint = 1'b1;
        take("cr_b0", 8'h31, 1'b1, 1'b0);
        take("cr_b1", 8'h32, 1'b0, 1'b0);
        take("cr_b2", 8'h33, 1'b0, 1'b0);
        take("cr_b3", 8'h34, 1'b0, 1'b0);
        take("cr_b4", 8'h35, 1'b0, 1'b0);
        take("cr_b5", 8'h36, 1'b0, 1'b0);
        take("cr_b6", 8'h37, 1'b0, 1'b0);
        take("cr_b7", 8'h38, 1'b0, 1'b0);
`ifdef UNPACK_CRC16_EN
        begin
            int n = 0;
            wait_valid("cr_b8");
            chk_byte("cr_b8", 8'h39, 1'b0, 1'b1);
            @(negedge clk);
            while (crc_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("crc_valid", 32'(crc_valid), 32'd1);
            chk("crc_value", 32'(crc16), 32'h29B1);
            @(negedge clk);
            chk("crc_valid_pulse", 32'(crc_valid), 32'd0);
            chk("crc_hold", 32'(crc16), 32'h29B1);
            chk("crc_pulses", 32'(n_crcv - c0), 32'd1);
        end
`else
        take("cr_b8", 8'h39, 1'b0, 1'b1);
        wait_idle("cr");
        chk("crc_off_value", 32'(crc16), 32'd0);
        chk("crc_off_pulses", 32'(n_crcv - c0), 32'd0);
`endif
        repeat (5) @(negedge clk);

        chk("read_min_gap_ok", 32'(min_gap >= 3), 32'd1);
        chk("read_legal", 32'(bad_rd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
